// File: rtl/ysyx_22050598_axi_rd_arb_pkg.sv
// Shared definitions for the read-side AXI arbiter: FSM states, fixed AR
// attributes (kept identical to the write path) and requester ids.
package ysyx_22050598_axi_rd_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } rd_state_e;

   localparam logic [2:0] AR_SIZE_8B    = 3'b011;
   localparam logic [1:0] AR_BURST_INCR = 2'b01;
   localparam logic [3:0] AR_CACHE      = 4'b0011;
   localparam logic [2:0] AR_PROT       = 3'b000;
   localparam logic [3:0] AR_QOS        = 4'b0000;

   localparam logic ID_IFU = 1'b0;
   localparam logic ID_LSU = 1'b1;

   // Cache-line reads are two beats, device reads are one
   function automatic logic [7:0] ar_len(input logic dev);
      return dev ? 8'd0 : 8'd1;
   endfunction

endpackage

// File: rtl/ysyx_22050598_axi_rd_arb_rr_arb2.sv
// Two-requester round-robin picker. Bit 0 is the IFU, bit 1 the LSU.
module ysyx_22050598_rr_arb2
   import ysyx_22050598_axi_rd_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic last_q;
   logic last_d;

   // Lone requester wins; on a tie the one not granted last wins
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (&req_i) gnt_o = (last_q == ID_IFU) ? 2'b10 : 2'b01;
         else        gnt_o = req_i;
      end
      last_d = (|gnt_o) ? gnt_o[1] : last_q;
   end

   // Remember the winner of every grant
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) last_q <= ID_IFU;
      else       last_q <= last_d;
   end

endmodule

// File: rtl/ysyx_22050598_axi_rd_arb.sv
// Shares one AXI AR/R channel pair between IFU and LSU: one outstanding
// read, 2-beat line fill or 1-beat device read, registered 128-bit response.
module ysyx_22050598_axi_rd_arb
   import ysyx_22050598_axi_rd_arb_pkg::*;
#(
   parameter int AW = 64,
   parameter int DW = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ifu_req_valid,
   input  logic [AW-1:0]   ifu_req_addr,
   output logic            ifu_req_ready,
   input  logic            lsu_req_valid,
   input  logic [AW-1:0]   lsu_req_addr,
   input  logic            lsu_req_dev,
   output logic            lsu_req_ready,
   output logic            rsp_valid,
   output logic            rsp_id,
   output logic [2*DW-1:0] rsp_data,
   output logic            rsp_err,
   output logic            M_AXI_ARID,
   output logic [AW-1:0]   M_AXI_ARADDR,
   output logic [7:0]      M_AXI_ARLEN,
   output logic [2:0]      M_AXI_ARSIZE,
   output logic [1:0]      M_AXI_ARBURST,
   output logic [3:0]      M_AXI_ARCACHE,
   output logic [2:0]      M_AXI_ARPROT,
   output logic [3:0]      M_AXI_ARQOS,
   output logic            M_AXI_ARVALID,
   input  logic            M_AXI_ARREADY,
   input  logic            M_AXI_RID,
   input  logic [DW-1:0]   M_AXI_RDATA,
   input  logic [1:0]      M_AXI_RRESP,
   input  logic            M_AXI_RLAST,
   input  logic            M_AXI_RVALID,
   output logic            M_AXI_RREADY
);

   rd_state_e          state_q;
   logic               id_q, dev_q, cnt_q, err_q;
   logic [AW-1:0]      addr_q;
   logic               arvalid_q, rready_q, rsp_valid_q, rsp_err_q;
   logic [2*DW-1:0]    rsp_data_q;
   logic [1:0][DW-1:0] beat_q, beat_d;
   logic [1:0]         gnt;
   logic               dev_d;
   logic [AW-1:0]      addr_d;
   logic               beat_hs, last_exp, beat_err;

   ysyx_22050598_rr_arb2 u_arb (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (state_q == S_IDLE),
      .req_i ({lsu_req_valid, ifu_req_valid}),
      .gnt_o (gnt)
   );

   assign ifu_req_ready = gnt[0];
   assign lsu_req_ready = gnt[1];

   // Beats only count while collecting data; RREADY is high exactly then
   assign beat_hs  = (state_q == S_DATA) & M_AXI_RVALID;
   assign last_exp = (cnt_q == ~dev_q);
   assign beat_err = (M_AXI_RID != id_q) | (M_AXI_RRESP != 2'b00) | (M_AXI_RLAST != last_exp);

   // Winner's address (line-aligned unless device) and incoming beat placement
   always_comb begin
      dev_d  = gnt[1] & lsu_req_dev;
      addr_d = gnt[1] ? lsu_req_addr : ifu_req_addr;
      if (!dev_d) addr_d[3:0] = 4'h0;
      beat_d = beat_q;
      beat_d[cnt_q] = M_AXI_RDATA;
   end

   // Read transaction FSM with registered channel and response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         id_q        <= ID_IFU;
         dev_q       <= 1'b0;
         cnt_q       <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         beat_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (|gnt) begin
               id_q      <= gnt[1];
               dev_q     <= dev_d;
               addr_q    <= addr_d;
               arvalid_q <= 1'b1;
               state_q   <= S_ADDR;
            end
            S_ADDR: if (M_AXI_ARREADY) begin
               arvalid_q <= 1'b0;
               rready_q  <= 1'b1;
               cnt_q     <= 1'b0;
               state_q   <= S_DATA;
            end
            S_DATA: if (beat_hs) begin
               beat_q <= beat_d;
               cnt_q  <= cnt_q + 1'b1;
               err_q  <= err_q | beat_err;
               if (M_AXI_RLAST) begin
                  rready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= err_q | beat_err;
                  rsp_data_q  <= dev_q ? {beat_d[0], beat_d[0]} : {beat_d[1], beat_d[0]};
                  state_q     <= S_RESP;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               err_q       <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign M_AXI_ARID    = id_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARLEN   = ar_len(dev_q);
   assign M_AXI_ARSIZE  = AR_SIZE_8B;
   assign M_AXI_ARBURST = AR_BURST_INCR;
   assign M_AXI_ARCACHE = AR_CACHE;
   assign M_AXI_ARPROT  = AR_PROT;
   assign M_AXI_ARQOS   = AR_QOS;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = id_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_ysyx_22050598_axi_rd_arb.sv
// Directed bench for the read arbiter with a transaction-level model and a
// per-cycle response checker.
module tb_ysyx_22050598_axi_rd_arb;

   logic          clk = 1'b0, rst = 1'b1;
   logic          ifu_req_valid = 0, lsu_req_valid = 0, lsu_req_dev = 0;
   logic [63:0]   ifu_req_addr = 0, lsu_req_addr = 0;
   logic          ifu_req_ready, lsu_req_ready;
   logic          rsp_valid, rsp_id, rsp_err;
   logic [127:0]  rsp_data;
   logic          ARID, ARVALID, ARREADY = 0, RREADY;
   logic [63:0]   ARADDR;
   logic [7:0]    ARLEN;
   logic [2:0]    ARSIZE, ARPROT;
   logic [1:0]    ARBURST;
   logic [3:0]    ARCACHE, ARQOS;
   logic          RID = 0, RLAST = 0, RVALID = 0;
   logic [63:0]   RDATA = 0;
   logic [1:0]    RRESP = 0;

   ysyx_22050598_axi_rd_arb dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
      .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_dev(lsu_req_dev),
      .lsu_req_ready(lsu_req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
      .M_AXI_ARBURST(ARBURST), .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT), .M_AXI_ARQOS(ARQOS),
      .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
      .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // ---------------- model state ----------------
   typedef struct {int cyc; logic id; logic [127:0] data; logic err;} exp_t;
   exp_t        expq[$];
   logic        m_last = 0;          // 0 = IFU granted last
   logic        m_id, m_dev;
   logic [63:0] m_addr;
   int          m_T, m_w;
   logic [63:0] m_buf[2] = '{64'h0, 64'h0};
   logic [63:0] b_data[3];
   logic        b_last[3];
   logic [1:0]  b_resp[3];
   logic        b_idov = 0, b_idv = 0;
   logic        obs_lsu;
   int          last_rsp_cyc = 0;
   logic [127:0] last_rsp_data = 0;

   // Response checker: every cycle, a pulse must match the head expectation
   always @(negedge clk) if (!rst) begin
      if (rsp_valid) begin
         if (expq.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
         else begin
            chk("rsp_cycle", cyc, expq[0].cyc);
            chk("rsp_id", rsp_id, expq[0].id);
            chk("rsp_data", rsp_data, expq[0].data);
            chk("rsp_err", rsp_err, expq[0].err);
            last_rsp_cyc  = cyc;
            last_rsp_data = rsp_data;
            void'(expq.pop_front());
         end
      end else if (expq.size() > 0 && cyc > expq[0].cyc) begin
         chk("rsp_missing", rsp_valid, 1'b1);
         void'(expq.pop_front());
      end
   end

   task automatic set_beats(input logic [63:0] d0, input logic l0, input logic [1:0] r0,
                            input logic [63:0] d1, input logic l1, input logic [1:0] r1,
                            input logic [63:0] d2, input logic l2, input logic [1:0] r2);
      b_data = '{d0, d1, d2}; b_last = '{l0, l1, l2}; b_resp = '{r0, r1, r2};
   endtask

   // Raise requests for one cycle; model picks the winner and the AR payload
   task automatic t_req(input logic iv, input logic lv, input logic [63:0] ia,
                        input logic [63:0] la, input logic ldev);
      logic win;
      logic [63:0] a;
      @(posedge clk); #1;
      ifu_req_valid = iv; ifu_req_addr = ia;
      lsu_req_valid = lv; lsu_req_addr = la; lsu_req_dev = ldev;
      m_T = cyc;
      win = (iv && lv) ? ~m_last : lv;
      m_last = win; m_id = win; m_dev = win & ldev;
      a = win ? la : ia;
      m_addr = m_dev ? a : {a[63:4], 4'h0};
      @(negedge clk);
      chk("ifu_ready", ifu_req_ready, iv && !win);
      chk("lsu_ready", lsu_req_ready, win);
      obs_lsu = lsu_req_ready;
      @(posedge clk); #1;
      ifu_req_valid = 0; lsu_req_valid = 0; lsu_req_dev = 0;
   endtask

   // Address phase: ARREADY after w stall cycles, optional stray R beats
   task automatic t_addr(input int w, input logic junk);
      m_w = w;
      for (int k = 0; k <= w; k++) begin
         ARREADY = (k == w);
         if (junk) begin RVALID = 1; RDATA = 64'hBAD0_BAD0_BAD0_BAD0; RLAST = 1; RID = m_id; end
         @(negedge clk);
         chk("arvalid", ARVALID, 1'b1);
         chk("araddr", ARADDR, m_addr);
         chk("arlen", ARLEN, m_dev ? 8'd0 : 8'd1);
         chk("arid", ARID, m_id);
         chk("arsize_burst", {ARSIZE, ARBURST}, {3'b011, 2'b01});
         chk("rready_addr", RREADY, 1'b0);
         @(posedge clk); #1;
      end
      ARREADY = 0; RVALID = 0; RLAST = 0;
   endtask

   // Data phase: n beats back to back; optionally queue the expected response
   task automatic t_beats(input int n, input logic push);
      logic e = 0;
      int idx;
      for (int i = 0; i < n; i++) begin
         RVALID = 1; RDATA = b_data[i]; RLAST = b_last[i]; RRESP = b_resp[i];
         RID = b_idov ? b_idv : m_id;
         idx = i % 2;
         m_buf[idx] = b_data[i];
         e |= (RID != m_id) || (b_resp[i] != 2'b00) || (b_last[i] != (idx == (m_dev ? 0 : 1)));
         @(negedge clk);
         chk("rready_data", RREADY, 1'b1);
         chk("arvalid_data", ARVALID, 1'b0);
         @(posedge clk); #1;
      end
      RVALID = 0; RLAST = 0; RRESP = 0; RID = 0;
      if (push)
         expq.push_back('{m_T + 2 + m_w + n, m_id,
                          m_dev ? {m_buf[0], m_buf[0]} : {m_buf[1], m_buf[0]}, e});
   endtask

   task automatic t_wait_rsp();
      for (int k = 0; k < 50 && expq.size() > 0; k++) begin @(negedge clk); #1; end
      if (expq.size() > 0) begin
         chk("rsp_timeout", expq.size(), 0);
         expq.delete();
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_arvalid"}, ARVALID, 1'b0);
      chk({tag, "_rready"}, RREADY, 1'b0);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk({tag, "_rsp_data"}, rsp_data, 128'h0);
      chk({tag, "_rsp_err"}, rsp_err, 1'b0);
      chk({tag, "_araddr"}, ARADDR, 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [2:0] tie_order;

   initial begin
      set_beats(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk_reset_vals("reset");

      // IFU line fill
      t_req(1, 0, 64'h8000_0014, 0, 0);
      t_addr(0, 0);
      set_beats(64'h1111_1111_1111_1111, 0, 0, 64'h2222_2222_2222_2222, 1, 0, 0, 0, 0);
      t_beats(2, 1);
      t_wait_rsp();
      chk("t1_araddr_lit", ARADDR, 64'h8000_0010);
      chk("t1_latency", last_rsp_cyc - m_T, 4);
      chk("t1_data_lit", last_rsp_data, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      // Three ties in a row: round-robin must alternate starting with LSU
      for (int k = 0; k < 3; k++) begin
         t_req(1, 1, 64'h8000_1000 + 64'(k * 16), 64'h8000_2008 + 64'(k * 16), 0);
         tie_order[2-k] = obs_lsu;
         t_addr(0, 0);
         set_beats(64'hA0 + 64'(k), 0, 0, 64'hB0 + 64'(k), 1, 0, 0, 0, 0);
         t_beats(2, 1);
         t_wait_rsp();
      end
      chk("tie_order_lit", tie_order, 3'b101);

      // LSU device read, single beat, address untouched
      t_req(0, 1, 0, 64'hA000_03F8, 1);
      t_addr(0, 0);
      set_beats(64'hDEAD, 1, 0, 0, 0, 0, 0, 0, 0);
      t_beats(1, 1);
      t_wait_rsp();
      chk("dev_araddr_lit", ARADDR, 64'hA000_03F8);
      chk("dev_latency", last_rsp_cyc - m_T, 3);
      chk("dev_data_lit", last_rsp_data, {64'hDEAD, 64'hDEAD});

      // ARREADY stalled 5 cycles with stray R beats that must be ignored
      t_req(1, 0, 64'h8000_0300, 0, 0);
      t_addr(5, 1);
      set_beats(64'h3333, 0, 0, 64'h4444, 1, 0, 0, 0, 0);
      t_beats(2, 1);
      t_wait_rsp();
      chk("stall_latency", last_rsp_cyc - m_T, 9);

      // SLVERR on beat 1
      t_req(1, 0, 64'h8000_0400, 0, 0);
      t_addr(0, 0);
      set_beats(64'h5555, 0, 0, 64'h6666, 1, 2, 0, 0, 0);
      t_beats(2, 1);
      t_wait_rsp();

      // RLAST on beat 0 of a line fill: early end, stale upper half
      t_req(1, 0, 64'h8000_0500, 0, 0);
      t_addr(0, 0);
      set_beats(64'h7777, 1, 0, 0, 0, 0, 0, 0, 0);
      t_beats(1, 1);
      t_wait_rsp();

      // Wrong RID on an LSU read
      t_req(0, 1, 0, 64'h8000_060C, 0);
      b_idov = 1; b_idv = 0;
      t_addr(0, 0);
      set_beats(64'h8888, 0, 0, 64'h9999, 1, 0, 0, 0, 0);
      t_beats(2, 1);
      b_idov = 0;
      t_wait_rsp();

      // Third beat wraps the counter and overwrites beat 0
      t_req(1, 0, 64'h8000_0700, 0, 0);
      t_addr(0, 0);
      set_beats(64'hAAAA, 0, 0, 64'hBBBB, 0, 0, 64'hCCCC, 1, 0);
      t_beats(3, 1);
      t_wait_rsp();
      chk("wrap_data_lit", last_rsp_data, {64'hBBBB, 64'hCCCC});

      // Reset after one beat of a line fill, then a clean transaction
      t_req(1, 0, 64'h8000_0800, 0, 0);
      t_addr(0, 0);
      set_beats(64'hEEEE, 0, 0, 0, 0, 0, 0, 0, 0);
      t_beats(1, 0);
      rst = 1;
      expq.delete();
      m_last = 0; m_buf = '{64'h0, 64'h0};
      @(negedge clk);
      chk_reset_vals("midrst");
      @(posedge clk); #1 rst = 0;
      t_req(1, 0, 64'h8000_0904, 0, 0);
      t_addr(0, 0);
      set_beats(64'h1234, 0, 0, 64'h5678, 1, 0, 0, 0, 0);
      t_beats(2, 1);
      t_wait_rsp();
      chk("post_rst_latency", last_rsp_cyc - m_T, 4);
      chk("post_rst_data_lit", last_rsp_data, {64'h5678, 64'h1234});

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22050598_axi_rd_arb.md
# ysyx_22050598_axi_rd_arb

Read-side AXI4 master controller sharing one AR/R channel pair between the IFU and the LSU. It accepts one request at a time, drives the AR handshake, collects a 2-beat cache-line burst or a 1-beat device read, and returns a registered 128-bit response to the winning requester. It sits between the core's memory request ports and the CPU-level AXI master, replacing ad-hoc edge-detected read sequencing with explicit valid/ready handshakes and round-robin arbitration.

## Interface
- AW, default 64: address width.
- DW, default 64: AXI data width; the response is 2*DW.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_addr  in  AW  IFU address; always cacheable.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- lsu_req_valid  in  1  LSU read request.
- lsu_req_addr  in  AW  LSU address.
- lsu_req_dev  in  1  1 = device access (single beat, unaligned address).
- lsu_req_ready  out  1  LSU request accepted this cycle.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  0 = IFU, 1 = LSU.
- rsp_data  out  2*DW  {beat1, beat0}; device reads return {beat0, beat0}.
- rsp_err  out  1  RRESP≠OKAY, RID mismatch, or RLAST framing error.
- M_AXI_ARID  out  1  equals the granted id.
- M_AXI_ARADDR  out  AW  captured address.
- M_AXI_ARLEN  out  8  1 for cacheable, 0 for device.
- M_AXI_ARSIZE / ARBURST  out  3 / 2  fixed 8-byte, INCR.
- M_AXI_ARVALID  in/out: out  1.
- M_AXI_ARREADY  in  1.
- M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID  in  1/DW/2/1/1.
- M_AXI_RREADY  out  1.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: arbitrate the valid requesters; on grant, pulse the winner's req_ready, capture id/addr/dev, → ADDR.
  - Cacheable address is captured with [3:0] cleared; device address is captured unmodified.
- Arbitration: a single valid requester wins. When both are valid, the requester not granted last wins; last_grant resets to IFU, so LSU wins the first tie.
- ADDR: ARVALID=1 with stable payload until ARREADY; on handshake → DATA with beat counter = 0.
- DATA: RREADY=1. Each RVALID beat stores RDATA into buffer[cnt] and increments cnt.
  - Expected last beat: cnt==ARLEN. RLAST must equal (cnt==ARLEN); any mismatch sets the error flag.
  - The burst always terminates on the RLAST beat.
  - RID≠captured id or RRESP≠0 on any beat sets the error flag.
  - On the RLAST beat → RESP.
- RESP: rsp_valid=1 for exactly one cycle with rsp_id/rsp_data/rsp_err; error flag is cleared; → IDLE.
- Requesters keep req_valid low until their rsp_valid; a request held after ready is treated as a new request.
- No response back-pressure: a requester must consume rsp_valid when it arrives.

## Timing
- Reset values: state IDLE; ARVALID, RREADY, rsp_valid, both req_ready = 0; rsp_data, rsp_err, buffer, ARADDR = 0; last_grant = IFU.
- req_ready is combinational in IDLE: req_valid → ready in the same cycle.
- ARVALID rises the cycle after grant.
- Zero-wait slave, cacheable read: grant at T, AR handshake at T+1, beats at T+2 and T+3, rsp_valid at T+4.
- Zero-wait slave, device read: rsp_valid at T+3.
- Back-to-back requests: the next grant occurs in the IDLE cycle after RESP, giving a minimum 1 idle cycle between transactions.
- RVALID outside DATA is ignored (RREADY=0).
- A beat arriving in the same cycle as the AR handshake is not accepted.
- A reset asserted mid-transaction returns the block to reset values immediately; the outstanding AXI burst is abandoned, and the slave is reset with it.
- Beat counter width is 1 bit; a third beat without RLAST wraps the counter, overwrites buffer[0], and sets rsp_err.

## Structure
- Shared defines header: state encodings, ARSIZE/ARBURST/ARCACHE/ARPROT constants, and the requester id values.
  - ARCACHE/ARPROT/ARQOS are driven with the same constants as the write path.
- Natural sub-module: ysyx_22050598_rr_arb2, a two-requester round-robin picker with a last-grant register updated on grant.
- All registers use the team's asynchronous-reset dff primitives.

## Test plan
- IFU only, addr 0x8000_0014, slave returns 0x11…, 0x22… with RLAST on beat 2:
  - expect ARADDR 0x8000_0010, ARLEN 1, ARID 0;
  - rsp_valid at T+4 with rsp_data {0x22…, 0x11…}, rsp_id 0, rsp_err 0.
- LSU device read, addr 0xA000_03F8, single beat 0xDEAD:
  - expect ARLEN 0, ARADDR unmodified, ARID 1;
  - rsp_data {0xDEAD, 0xDEAD}.
- Both requesters valid at the same cycle three times in a row:
  - expect grant order LSU, IFU, LSU;
  - each gets exactly one rsp_valid tagged with its id.
- ARREADY held low 5 cycles:
  - ARVALID and ARADDR stay stable;
  - rsp_valid is delayed by exactly 5 cycles.
- Error cases, each expecting the response still delivered with rsp_err=1:
  - RRESP=SLVERR on beat 1;
  - RLAST on beat 0 of a cacheable read;
  - RID=0 on an LSU read.
- rst asserted during DATA after 1 beat:
  - all outputs at reset values next edge;
  - a new IFU request after reset completes normally.
